// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between the core and a
// host/debug requester, and steers the next-cycle read data back to whoever
// issued the read.
// Latency: grants and mem_* are combinational (zero added latency); read data
// returns 1 cycle after the grant.
// Backpressure: a requester holds req and its fields until it sees its gnt.
// The core has fixed priority, but a host refused MAXWAIT times in a row is
// forced ahead. The host can lock the port for atomic bursts.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   c_req/we/addr/size/wdata, c_gnt, c_rvalid, c_rdata   core requester
//   h_req/we/addr/size/wdata, h_lock, h_gnt, h_rvalid, h_rdata  host requester
//   mem_read, mem_wren, mem_addr, mem_size, mem_wdata, mem_rdata  memory macro

module mem_port_arbiter #(
    parameter int WDATA   = 32,
    parameter int WPTR    = 32,
    parameter int MAXWAIT = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             c_req,
    input  logic             c_we,
    input  logic [WPTR-1:0]  c_addr,
    input  logic [2:0]       c_size,
    input  logic [WDATA-1:0] c_wdata,
    output logic             c_gnt,
    output logic             c_rvalid,
    output logic [WDATA-1:0] c_rdata,

    input  logic             h_req,
    input  logic             h_we,
    input  logic [WPTR-1:0]  h_addr,
    input  logic [2:0]       h_size,
    input  logic [WDATA-1:0] h_wdata,
    input  logic             h_lock,
    output logic             h_gnt,
    output logic             h_rvalid,
    output logic [WDATA-1:0] h_rdata,

    output logic             mem_read,
    output logic             mem_wren,
    output logic [WPTR-1:0]  mem_addr,
    output logic [2:0]       mem_size,
    output logic [WDATA-1:0] mem_wdata,
    input  logic [WDATA-1:0] mem_rdata
);

    localparam int            CW       = $clog2(MAXWAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAXWAIT);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            rsp_vld_q, rsp_vld_d;
    logic            rsp_host_q, rsp_host_d;   // owner of the in-flight read

    logic            host_first;

    // ------------------------------------------------------------------
    // Grant decision. Everything is forced off while rst is high so no
    // access reaches the memory during reset.
    // ------------------------------------------------------------------
    always_comb begin
        host_first = 1'b0;
        c_gnt      = 1'b0;
        h_gnt      = 1'b0;
        if (!rst) begin
            if (state_q == ST_LOCK) begin
                // Host-exclusive, including the cycle in which h_lock drops.
                h_gnt = h_req;
            end else begin
                // Host wins when alone, or once it has been refused
                // MAXWAIT times while the core kept the port.
                host_first = h_req && (!c_req || (wait_cnt_q == WAIT_MAX));
                h_gnt      = host_first;
                c_gnt      = c_req && !host_first;
            end
        end
    end

    // ------------------------------------------------------------------
    // Memory port mux. With no grant the core's fields are presented so
    // the address bus does not toggle needlessly on idle cycles.
    // ------------------------------------------------------------------
    always_comb begin
        mem_read = (c_gnt && !c_we) || (h_gnt && !h_we);
        mem_wren = (c_gnt &&  c_we) || (h_gnt &&  h_we);
        if (h_gnt) begin
            mem_addr  = h_addr;
            mem_size  = h_size;
            mem_wdata = h_wdata;
        end else begin
            mem_addr  = c_addr;
            mem_size  = c_size;
            mem_wdata = c_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: lock FSM, host starvation counter, response tracking.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            ST_ARB: begin
                if (h_gnt) begin
                    wait_cnt_d = '0;
                    // A lock request only takes effect together with a grant.
                    if (h_lock) begin
                        state_d = ST_LOCK;
                    end
                end else if (h_req && (wait_cnt_q != WAIT_MAX)) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_LOCK: begin
                // The core never competes here, so nothing to count.
                wait_cnt_d = '0;
                // Leave regardless of h_req; this cycle stays host-only.
                if (!h_lock) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d    = ST_ARB;
                wait_cnt_d = '0;
            end
        endcase

        // Only reads produce a response; writes are fire-and-forget.
        rsp_vld_d  = mem_read;
        rsp_host_d = h_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARB;
            wait_cnt_q <= '0;
            rsp_vld_q  <= 1'b0;
            rsp_host_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_host_q <= rsp_host_d;
        end
    end

    // ------------------------------------------------------------------
    // Response steering. rst gates the valids directly so a read granted
    // just before reset never returns data once reset is asserted.
    // The non-owner sees zero data rather than a copy of mem_rdata.
    // ------------------------------------------------------------------
    always_comb begin
        c_rvalid = rsp_vld_q && !rsp_host_q && !rst;
        h_rvalid = rsp_vld_q &&  rsp_host_q && !rst;
        c_rdata  = c_rvalid ? mem_rdata : '0;
        h_rdata  = h_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration rules and a simple memory macro.
// Latency: n/a (testbench). Backpressure: requesters hold until granted.

module tb_mem_port_arbiter;

    localparam int WDATA   = 32;
    localparam int WPTR    = 32;
    localparam int MAXWAIT = 8;

    logic             clk;
    logic             rst;
    logic             c_req, c_we;
    logic [WPTR-1:0]  c_addr;
    logic [2:0]       c_size;
    logic [WDATA-1:0] c_wdata;
    logic             c_gnt, c_rvalid;
    logic [WDATA-1:0] c_rdata;
    logic             h_req, h_we, h_lock;
    logic [WPTR-1:0]  h_addr;
    logic [2:0]       h_size;
    logic [WDATA-1:0] h_wdata;
    logic             h_gnt, h_rvalid;
    logic [WDATA-1:0] h_rdata;
    logic             mem_read, mem_wren;
    logic [WPTR-1:0]  mem_addr;
    logic [2:0]       mem_size;
    logic [WDATA-1:0] mem_wdata;
    logic [WDATA-1:0] mem_rdata;

    mem_port_arbiter #(.WDATA(WDATA), .WPTR(WPTR), .MAXWAIT(MAXWAIT)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_size(c_size),
        .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_size(h_size),
        .h_wdata(h_wdata), .h_lock(h_lock), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
        .h_rdata(h_rdata),
        .mem_read(mem_read), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_size(mem_size), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory macro: word store, read data appears the cycle after mem_read.
    logic [31:0] mem_arr [logic [31:0]];

    // Reference model state, in terms of the rules rather than registers.
    bit locked;          // host owns the port exclusively
    int refusals;        // consecutive host refusals, capped at MAXWAIT
    bit pend;            // a read was granted last cycle
    bit pend_host;       // ... and it was the host's

    // Values sampled in the last cycle, for directed checks.
    logic s_cg, s_hg, s_crv, s_hrv, s_mrd, s_mwr;
    logic [31:0] s_crd, s_hrd;
    bit   e_cg_last;
    bit   e_hg_last;

    task automatic cycle();
        bit          e_cg, e_hg, e_crv, e_hrv;
        logic [31:0] e_addr, e_wdata, e_crd, e_hrd;
        logic [2:0]  e_size;
        bit          e_rd, e_wr;
        logic        cap_rd, cap_wr;
        logic [31:0] cap_addr, cap_wdata;

        @(negedge clk);
        e_cg = 0;
        e_hg = 0;
        if (!rst) begin
            if (locked) begin
                e_hg = h_req;
            end else if (h_req && c_req) begin
                if (refusals >= MAXWAIT) e_hg = 1;
                else                     e_cg = 1;
            end else begin
                e_hg = h_req;
                e_cg = c_req;
            end
        end
        e_rd    = (e_cg && !c_we) || (e_hg && !h_we);
        e_wr    = (e_cg &&  c_we) || (e_hg &&  h_we);
        e_addr  = e_hg ? h_addr  : c_addr;
        e_size  = e_hg ? h_size  : c_size;
        e_wdata = e_hg ? h_wdata : c_wdata;
        e_crv   = !rst && pend && !pend_host;
        e_hrv   = !rst && pend &&  pend_host;
        e_crd   = e_crv ? mem_rdata : 32'h0;
        e_hrd   = e_hrv ? mem_rdata : 32'h0;

        check("c_gnt",     c_gnt,     e_cg);
        check("h_gnt",     h_gnt,     e_hg);
        check("mem_read",  mem_read,  e_rd);
        check("mem_wren",  mem_wren,  e_wr);
        check("mem_addr",  mem_addr,  e_addr);
        check("mem_size",  mem_size,  e_size);
        check("mem_wdata", mem_wdata, e_wdata);
        check("c_rvalid",  c_rvalid,  e_crv);
        check("c_rdata",   c_rdata,   e_crd);
        check("h_rvalid",  h_rvalid,  e_hrv);
        check("h_rdata",   h_rdata,   e_hrd);

        s_cg = c_gnt;  s_hg = h_gnt;  s_crv = c_rvalid;  s_hrv = h_rvalid;
        s_crd = c_rdata; s_hrd = h_rdata; s_mrd = mem_read; s_mwr = mem_wren;
        e_cg_last = e_cg;
        e_hg_last = e_hg;
        cap_rd = mem_read; cap_wr = mem_wren; cap_addr = mem_addr; cap_wdata = mem_wdata;

        // Model update at the clock edge.
        if (rst) begin
            locked   = 0;
            refusals = 0;
            pend     = 0;
        end else begin
            pend      = e_rd;
            pend_host = e_hg;
            if (locked) begin
                refusals = 0;
                locked   = h_lock;
            end else if (e_hg) begin
                refusals = 0;
                locked   = h_lock;
            end else if (h_req && refusals < MAXWAIT) begin
                refusals = refusals + 1;
            end
        end

        @(posedge clk);
        #1;
        if (cap_wr === 1'b1) mem_arr[cap_addr] = cap_wdata;
        if (cap_rd === 1'b1)
            mem_rdata = mem_arr.exists(cap_addr) ? mem_arr[cap_addr] : (cap_addr ^ 32'hA5A5_0000);
        else
            mem_rdata = $urandom;   // junk: must never leak to rdata
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = '0; c_size = 3'd2; c_wdata = '0;
        h_req = 0; h_we = 0; h_addr = '0; h_size = 3'd2; h_wdata = '0; h_lock = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        cycle();
        cycle();
        rst = 0;
    endtask

    logic [31:0] rd_tbl [3];

    initial begin
        locked = 0; refusals = 0; pend = 0; pend_host = 0;
        mem_rdata = '0;
        mem_arr[32'h0] = 32'h11;
        mem_arr[32'h4] = 32'h22;
        mem_arr[32'h8] = 32'h33;
        rd_tbl[0] = 32'h11; rd_tbl[1] = 32'h22; rd_tbl[2] = 32'h33;

        do_reset();
        check("rst_crv", s_crv, 0);
        check("rst_hrv", s_hrv, 0);
        check("rst_crd", s_crd, 0);
        check("rst_gnt", s_cg | s_hg, 0);

        // Core-only back-to-back reads.
        c_req = 1; c_we = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) c_addr = 32'(i * 4);
            else       c_req  = 0;
            cycle();
            if (i < 3) check("core_gnt", s_cg, 1);
            if (i > 0) begin
                check("core_rv", s_crv, 1);
                check("core_rd", s_crd, rd_tbl[i-1]);
            end
            check("core_hrv", s_hrv, 0);
        end

        // Both requesting continuously: host forced through on cycle 8.
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h40;
        h_req = 1; h_we = 0; h_addr = 32'h80;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("starve_hg", s_hg, (i == 8));
            check("starve_cg", s_cg, (i != 8));
        end
        idle_inputs();
        cycle();

        // Locked host write then read while the core waits.
        do_reset();
        h_req = 1; h_we = 1; h_addr = 32'h100; h_wdata = 32'hDEAD_BEEF; h_lock = 1;
        cycle();
        check("lk_wr_gnt", s_hg, 1);
        check("lk_wr_str", s_mwr, 1);
        h_we = 0; c_req = 1; c_addr = 32'h44;
        cycle();
        check("lk_rd_hg", s_hg, 1);
        check("lk_rd_cg", s_cg, 0);
        h_req = 0;
        cycle();
        check("lk_hrv", s_hrv, 1);
        check("lk_hrd", s_hrd, 32'hDEAD_BEEF);
        check("lk_hold_cg", s_cg, 0);
        h_lock = 0;
        cycle();
        check("lk_exit_cg", s_cg, 0);
        cycle();
        check("lk_after_cg", s_cg, 1);
        idle_inputs();
        cycle();

        // Alternating owners.
        do_reset();
        h_req = 1; h_we = 0; h_addr = 32'h0;
        cycle();
        check("alt0_hrv", s_hrv, 0);
        check("alt0_crv", s_crv, 0);
        h_req = 0; c_req = 1; c_we = 0; c_addr = 32'h4;
        cycle();
        check("alt1_hrv", s_hrv, 1);
        check("alt1_hrd", s_hrd, 32'h11);
        check("alt1_crv", s_crv, 0);
        c_req = 0;
        cycle();
        check("alt2_crv", s_crv, 1);
        check("alt2_crd", s_crd, 32'h22);
        check("alt2_hrv", s_hrv, 0);

        // Reset right after a locked host read.
        do_reset();
        h_req = 1; h_we = 0; h_addr = 32'h8; h_lock = 1;
        cycle();
        check("rl_hg", s_hg, 1);
        rst = 1; h_req = 0; c_req = 1; c_addr = 32'h4;
        cycle();
        check("rl_hrv", s_hrv, 0);
        check("rl_cg_rst", s_cg, 0);
        rst = 0;
        cycle();
        check("rl_cg", s_cg, 1);
        check("rl_hrv2", s_hrv, 0);

        // Idle cycle.
        idle_inputs();
        cycle();
        check("idle_rd", s_mrd, 0);
        check("idle_wr", s_mwr, 0);
        check("idle_gnt", s_cg | s_hg, 0);

        // Randomized traffic; requests held with stable fields until granted.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (!(c_req && !e_cg_last)) begin
                c_req   = ($urandom_range(0, 99) < 70);
                c_we    = ($urandom_range(0, 99) < 30);
                c_addr  = 32'($urandom_range(0, 15)) << 2;
                c_size  = 3'($urandom_range(0, 7));
                c_wdata = $urandom;
            end
            if (!(h_req && !e_hg_last)) begin
                h_req   = ($urandom_range(0, 99) < 50);
                h_we    = ($urandom_range(0, 99) < 40);
                h_addr  = 32'($urandom_range(0, 15)) << 2;
                h_size  = 3'($urandom_range(0, 7));
                h_wdata = $urandom;
            end
            h_lock = ($urandom_range(0, 99) < 25);
            cycle();
        end
        rst = 0;
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
